// File: rtl/instr_encoder_if.sv
// Bus bundle for instr_encoder: descriptor request channel in, memory write channel out.
// Handshake rule for both channels: a transfer happens on a rising clk edge where
// valid (in_valid / mem_we) and ready (in_ready / mem_ready) are both high; while valid
// is high and ready is low, the source holds its payload stable.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] words_written;
    logic        err_illegal;

    // Requester / memory side (drives descriptors, accepts writes).
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, words_written, err_illegal
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, words_written, err_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: turns MIPS-style descriptors into 32-bit words, buffers them in a
// small FIFO and streams them to instruction memory at consecutive byte addresses.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [31:0] fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        push;
    logic        pop;
    logic        op_legal;
    logic [31:0] enc_word;
    logic [31:0] addr_q;
    logic [15:0] count_q;
    logic        err_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // in_ready depends only on registered pointers, never on mem_ready, so a pop on
    // the same edge cannot open room for a push while full.
    assign bus.in_ready = !fifo_full;
    assign accept       = bus.in_valid && !fifo_full;
    assign push         = accept && op_legal;
    assign pop          = !fifo_empty && bus.mem_ready;

    assign bus.mem_we        = !fifo_empty;
    assign bus.mem_wdata     = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[AW-1:0]];
    assign bus.mem_addr      = addr_q;
    assign bus.words_written = count_q;
    assign bus.err_illegal   = err_q;

    // Encode the presented descriptor; unused fields are forced to zero.
    always_comb begin
        enc_word = 32'd0;
        op_legal = 1'b1;
        case (bus.in_op)
            4'd0: enc_word = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00};
            4'd1: enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
            4'd2: enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
            4'd3: enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24};
            4'd4: enc_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25};
            4'd5: enc_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: enc_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7: enc_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: enc_word = {6'h2b, bus.in_rs, bus.in_rt, bus.in_imm};
            default: op_legal = 1'b0;
        endcase
    end

    // FIFO storage; stale contents are harmless because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= enc_word;
        end
    end

    // Pointers, write address, completion counter and sticky illegal-op flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            addr_q  <= BASE_ADDR;
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                addr_q  <= addr_q + 32'd4;
                count_q <= count_q + 16'd1;
            end
            if (accept && !op_legal) begin
                err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus hand sequences for
// backpressure, illegal ops, address wrap and mid-stream reset.
module tb_instr_encoder;
    logic clk;
    logic reset;

    instr_encoder_if a_if ();
    instr_encoder_if b_if ();

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (a_if.slave)
    );

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (b_if.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] exp_word;
    } vec_t;

    vec_t        vecs [9];
    logic [63:0] exp_q [$];
    logic [31:0] exp_addr;
    logic [15:0] exp_words;
    logic        mon_en;
    int          checks;
    int          failures;

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed write must match the oldest expected {addr, word}.
    always @(negedge clk) begin
        if (mon_en && a_if.mem_we && a_if.mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {a_if.mem_addr, a_if.mem_wdata}, 64'd0);
            end else begin
                check("write_addr_data", {a_if.mem_addr, a_if.mem_wdata}, exp_q.pop_front());
            end
            check("words_before_write", {48'd0, a_if.words_written}, {48'd0, exp_words});
            exp_words = exp_words + 16'd1;
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        mon_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_if.in_valid  = 1'b0;
        a_if.mem_ready = 1'b0;
        b_if.in_valid  = 1'b0;
        b_if.mem_ready = 1'b0;
        reset          = 1'b0;
        exp_q.delete();
        exp_addr  = 32'h0;
        exp_words = 16'd0;
        mon_en    = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, {63'd0, a_if.in_ready}, 64'd1);
        check({tag, "_mem_we"}, {63'd0, a_if.mem_we}, 64'd0);
        check({tag, "_mem_addr"}, {32'd0, a_if.mem_addr}, 64'd0);
        check({tag, "_mem_wdata"}, {32'd0, a_if.mem_wdata}, 64'd0);
        check({tag, "_words"}, {48'd0, a_if.words_written}, 64'd0);
        check({tag, "_err"}, {63'd0, a_if.err_illegal}, 64'd0);
    endtask

    // Driver: present one descriptor, hold it until accepted, log the expected word.
    task automatic send(input vec_t v, input bit legal);
        bit done;
        done          = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_op    = v.op;
        a_if.in_rs    = v.rs;
        a_if.in_rt    = v.rt;
        a_if.in_rd    = v.rd;
        a_if.in_shamt = v.sh;
        a_if.in_imm   = v.imm;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (a_if.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        a_if.in_valid = 1'b0;
        if (!done) begin
            check("send_timeout", 64'd0, 64'd1);
        end else if (legal) begin
            exp_q.push_back({exp_addr, v.exp_word});
            exp_addr = exp_addr + 32'd4;
        end
    endtask

    // Wait for the FIFO to empty, then confirm nothing is left expected.
    task automatic drain(input string tag);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 50 && !idle; i++) begin
            @(negedge clk);
            if (!a_if.mem_we) idle = 1'b1;
        end
        check({tag, "_drained"}, {63'd0, idle}, 64'd1);
        check({tag, "_exp_q_empty"}, exp_q.size(), 64'd0);
        check({tag, "_words"}, {48'd0, a_if.words_written}, {48'd0, exp_words});
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        mon_en         = 1'b0;
        exp_addr       = 32'h0;
        exp_words      = 16'd0;
        reset          = 1'b1;
        a_if.in_valid  = 1'b0;
        a_if.in_op     = 4'd0;
        a_if.in_rs     = 5'd0;
        a_if.in_rt     = 5'd0;
        a_if.in_rd     = 5'd0;
        a_if.in_shamt  = 5'd0;
        a_if.in_imm    = 16'd0;
        a_if.mem_ready = 1'b0;
        b_if.in_valid  = 1'b0;
        b_if.in_op     = 4'd0;
        b_if.in_rs     = 5'd0;
        b_if.in_rt     = 5'd0;
        b_if.in_rd     = 5'd0;
        b_if.in_shamt  = 5'd0;
        b_if.in_imm    = 16'd0;
        b_if.mem_ready = 1'b0;

        vecs[0] = '{op: 4'd0, rs: 5'd7,  rt: 5'd5,  rd: 5'd4,  sh: 5'd2, imm: 16'h0000, exp_word: 32'h0005_2080};
        vecs[1] = '{op: 4'd7, rs: 5'd29, rt: 5'd8,  rd: 5'd0,  sh: 5'd0, imm: 16'h0004, exp_word: 32'h8FA8_0004};
        vecs[2] = '{op: 4'd1, rs: 5'd1,  rt: 5'd2,  rd: 5'd3,  sh: 5'd0, imm: 16'h0000, exp_word: 32'h0022_1820};
        vecs[3] = '{op: 4'd2, rs: 5'd3,  rt: 5'd4,  rd: 5'd5,  sh: 5'd9, imm: 16'h0000, exp_word: 32'h0064_2822};
        vecs[4] = '{op: 4'd3, rs: 5'd31, rt: 5'd31, rd: 5'd31, sh: 5'd0, imm: 16'h0000, exp_word: 32'h03FF_F824};
        vecs[5] = '{op: 4'd4, rs: 5'd0,  rt: 5'd1,  rd: 5'd2,  sh: 5'd0, imm: 16'h0000, exp_word: 32'h0001_1025};
        vecs[6] = '{op: 4'd6, rs: 5'd2,  rt: 5'd3,  rd: 5'd7,  sh: 5'd5, imm: 16'h8000, exp_word: 32'h2043_8000};
        vecs[7] = '{op: 4'd8, rs: 5'd29, rt: 5'd9,  rd: 5'd0,  sh: 5'd0, imm: 16'h0008, exp_word: 32'hAFA9_0008};
        vecs[8] = '{op: 4'd5, rs: 5'd1,  rt: 5'd2,  rd: 5'd0,  sh: 5'd0, imm: 16'hFFFF, exp_word: 32'h1022_FFFF};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_reset_state("reset");

        // Single add: one-cycle latency to mem_we, one word written after that edge.
        @(posedge clk);
        #1;
        a_if.mem_ready = 1'b1;
        send(vecs[2], 1'b1);
        @(negedge clk);
        check("lat_mem_we", {63'd0, a_if.mem_we}, 64'd1);
        check("lat_addr", {32'd0, a_if.mem_addr}, 64'd0);
        check("lat_wdata", {32'd0, a_if.mem_wdata}, 64'h0000_0000_0022_1820);
        @(posedge clk);
        #1;
        check("lat_words", {48'd0, a_if.words_written}, 64'd1);
        drain("single");

        // Full table streamed back-to-back with memory always ready.
        do_reset();
        a_if.mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i], 1'b1);
        end
        drain("table");
        check("table_addr_end", {32'd0, a_if.mem_addr}, 64'd36);

        // Backpressure: four fill the FIFO, the fifth waits until memory drains.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(vecs[i], 1'b1);
        end
        @(negedge clk);
        check("full_in_ready", {63'd0, a_if.in_ready}, 64'd0);
        fork
            send(vecs[4], 1'b1);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", {63'd0, a_if.in_ready}, 64'd0);
                    check("stall_head", {a_if.mem_addr, a_if.mem_wdata}, 64'h0000_0000_0005_2080);
                    check("stall_words", {48'd0, a_if.words_written}, 64'd0);
                end
                @(posedge clk);
                #1;
                a_if.mem_ready = 1'b1;
            end
        join
        drain("backpressure");
        check("bp_addr_end", {32'd0, a_if.mem_addr}, 64'd20);

        // Illegal op: accepted, nothing queued, sticky error; a following beq still encodes.
        do_reset();
        a_if.mem_ready = 1'b1;
        send('{op: 4'd12, rs: 5'd1, rt: 5'd1, rd: 5'd1, sh: 5'd1, imm: 16'h1234, exp_word: 32'h0}, 1'b0);
        @(negedge clk);
        check("illegal_err", {63'd0, a_if.err_illegal}, 64'd1);
        check("illegal_no_we", {63'd0, a_if.mem_we}, 64'd0);
        check("illegal_words", {48'd0, a_if.words_written}, 64'd0);
        @(posedge clk);
        #1;
        send(vecs[8], 1'b1);
        drain("illegal");
        check("illegal_sticky", {63'd0, a_if.err_illegal}, 64'd1);

        // Address wrap on the instance based at 0xFFFF_FFFC.
        do_reset();
        b_if.in_valid = 1'b1;
        b_if.in_op    = 4'd8;
        b_if.in_rs    = 5'd29;
        b_if.in_rt    = 5'd9;
        b_if.in_imm   = 16'h0008;
        repeat (2) begin
            @(negedge clk);
            check("wrap_in_ready", {63'd0, b_if.in_ready}, 64'd1);
            @(posedge clk);
            #1;
        end
        b_if.in_valid = 1'b0;
        @(negedge clk);
        check("wrap_first", {b_if.mem_addr, b_if.mem_wdata}, 64'hFFFF_FFFC_AFA9_0008);
        @(posedge clk);
        #1;
        b_if.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("wrap_second", {b_if.mem_addr, b_if.mem_wdata}, 64'h0000_0000_AFA9_0008);
        check("wrap_words1", {48'd0, b_if.words_written}, 64'd1);
        @(posedge clk);
        #1;
        check("wrap_words2", {48'd0, b_if.words_written}, 64'd2);
        check("wrap_idle", {63'd0, b_if.mem_we}, 64'd0);
        check("wrap_addr_end", {32'd0, b_if.mem_addr}, 64'd4);

        // Reset with three words stalled; memory ready and in_valid asserted during reset.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(vecs[i], 1'b1);
        end
        send('{op: 4'd13, rs: 5'd0, rt: 5'd0, rd: 5'd0, sh: 5'd0, imm: 16'h0, exp_word: 32'h0}, 1'b0);
        @(negedge clk);
        check("pre_reset_err", {63'd0, a_if.err_illegal}, 64'd1);
        check("pre_reset_we", {63'd0, a_if.mem_we}, 64'd1);
        @(posedge clk);
        #1;
        a_if.in_valid  = 1'b1;
        a_if.in_op     = 4'd1;
        reset          = 1'b1;
        mon_en         = 1'b0;
        a_if.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_if.in_valid  = 1'b0;
        a_if.mem_ready = 1'b0;
        reset          = 1'b0;
        exp_q.delete();
        exp_addr  = 32'h0;
        exp_words = 16'd0;
        mon_en    = 1'b1;
        check_reset_state("midreset");
        @(negedge clk);
        check("midreset_still_idle", {63'd0, a_if.mem_we}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
